shifter8_rsh_seq: RTL and testbench



---
 rtl/shifter_pkg.sv | 23 ++
 rtl/shifter8_rsh_seq_if.sv | 30 +++
 rtl/rsh1_stage.sv | 26 ++
 rtl/shifter8_rsh_seq.sv | 79 +++++++
 tb/tb_shifter8_rsh_seq.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the shifter8 datapath.
//   - Shift operation encodings (op field).
//   - FSM state encoding for the sequential right shifter.
//   - mx4: 4:1 single-bit mux used to build the per-bit fill logic.
package shifter_pkg;

    localparam logic [1:0] OP_LSR = 2'b00;
    localparam logic [1:0] OP_ASR = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;  // reserved, behaves as LSR

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // in[sel] selection; in is packed as {in3, in2, in1, in0}.
    function automatic logic mx4(input logic [3:0] in, input logic [1:0] sel);
        return in[sel];
    endfunction

endpackage

// File: rtl/shifter8_rsh_seq_if.sv
// Handshake/data bundle for shifter8_rsh_seq.
//   start  : request pulse (master -> slave)
//   op     : shift operation (master -> slave)
//   d_in   : operand (master -> slave)
//   shamt  : shift amount (master -> slave)
//   d_out  : working/result register (slave -> master)
//   busy   : shifting in progress (slave -> master)
//   done   : one-cycle completion pulse (slave -> master)
interface shifter8_rsh_seq_if #(
    parameter int WIDTH = 8,
    parameter int SW    = 3
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] d_in;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] d_out;
    logic             busy;
    logic             done;

    modport master (
        output start, op, d_in, shamt,
        input  d_out, busy, done
    );

    modport slave (
        input  start, op, d_in, shamt,
        output d_out, busy, done
    );
endinterface

// File: rtl/rsh1_stage.sv
// Combinational one-position right shift.
//   d  : operand
//   op : operation select (LSR / ASR / ROR / reserved=LSR)
//   q  : d shifted right by one, MSB fill chosen by op
// Each output bit is a 4:1 mux indexed by op; only the MSB has
// op-dependent inputs, the lower bits see d[i+1] on every leg.
module rsh1_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == WIDTH - 1) begin : g_msb
            // legs: RSV -> 0, ROR -> d[0], ASR -> sign, LSR -> 0
            assign q[i] = mx4({1'b0, d[0], d[WIDTH-1], 1'b0}, op);
        end else begin : g_low
            assign q[i] = mx4({4{d[i+1]}}, op);
        end
    end

endmodule

// File: rtl/shifter8_rsh_seq.sv
// Sequential right shifter: one bit position per clock for shamt clocks,
// under a start/busy/done handshake. Supports LSR, ASR and ROR.
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : slave side of shifter8_rsh_seq_if (start/op/d_in/shamt in,
//             d_out/busy/done out)
// busy/done are decoded straight from the state register, so every output
// is registered. Start is accepted in IDLE and DONE, ignored in SHIFT.
module shifter8_rsh_seq
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SW    = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    shifter8_rsh_seq_if.slave    bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [SW-1:0]    cnt_q,   cnt_d;
    logic [1:0]       op_q,    op_d;
    logic [WIDTH-1:0] shifted;

    rsh1_stage #(.WIDTH(WIDTH)) u_stage (
        .d  (data_q),
        .op (op_q),
        .q  (shifted)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            op_q    <= OP_LSR;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    data_d  = bus.d_in;
                    cnt_d   = bus.shamt;
                    op_d    = bus.op;
                    state_d = (bus.shamt != '0) ? SHIFT : DONE;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                data_d = shifted;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - SW'(1);
                end
                if (cnt_q == SW'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.d_out = data_q;
    assign bus.busy  = (state_q == SHIFT);
    assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_shifter8_rsh_seq.sv
module tb_shifter8_rsh_seq;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    shifter8_rsh_seq_if #(.WIDTH(8), .SW(3)) bus ();

    shifter8_rsh_seq #(.WIDTH(8), .SW(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] d;
        logic [2:0] s;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[6];

    // Reference: whole-word arithmetic on the operand, no per-bit stepping.
    function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] d,
                                         input int unsigned s);
        int unsigned v;
        int          sv;
        v = d;
        case (op)
            2'b01: begin
                sv = $signed(d);
                sv = sv >>> s;
                return sv[7:0];
            end
            2'b10: begin
                v = ((v >> s) | (v << (8 - s))) & 32'hFF;
                return v[7:0];
            end
            default: begin
                v = v >> s;
                return v[7:0];
            end
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Starts one operation at a negedge, then watches done with a bounded wait.
    task automatic do_op(input logic [1:0] o, input logic [7:0] d, input logic [2:0] s,
                         input logic [7:0] exp, input string nm);
        int edges;
        int busy_cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.d_in = d; bus.shamt = s;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.d_in  = 8'($urandom);
        bus.shamt = 3'($urandom);
        edges = 1;
        busy_cnt = 0;
        while (!bus.done && edges < 20) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            edges++;
        end
        check({nm, " latency"}, edges, int'(s) + 1);
        check({nm, " busy_cycles"}, busy_cnt, int'(s));
        check({nm, " d_out"}, int'(bus.d_out), int'(exp));
        @(negedge clk);
        check({nm, " done_pulse"}, int'(bus.done), 0);
        check({nm, " d_out_held"}, int'(bus.d_out), int'(exp));
    endtask

    initial begin
        int edges;
        int dones;
        logic [1:0] ro;
        logic [7:0] rd;
        logic [2:0] rs;

        vecs[0] = '{2'b00, 8'hB4, 3'd3, 8'h16, "lsr_b4_3"};
        vecs[1] = '{2'b01, 8'h96, 3'd2, 8'hE5, "asr_96_2"};
        vecs[2] = '{2'b10, 8'h01, 3'd7, 8'h02, "ror_01_7"};
        vecs[3] = '{2'b11, 8'h80, 3'd1, 8'h40, "rsv_80_1"};
        vecs[4] = '{2'b01, 8'h5A, 3'd0, 8'h5A, "zero_5a"};
        vecs[5] = '{2'b10, 8'hF0, 3'd4, 8'h0F, "ror_f0_4"};

        reset_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.d_in = 8'hAA; bus.shamt = 3'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset d_out", int'(bus.d_out), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        reset_n = 1'b1;

        foreach (vecs[i])
            do_op(vecs[i].op, vecs[i].d, vecs[i].s, vecs[i].exp, vecs[i].name);

        // Start during busy must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.d_in = 8'hFF; bus.shamt = 3'd5;
        @(negedge clk);                      // busy cycle 1
        bus.start = 1'b0;
        @(negedge clk);                      // busy cycle 2
        bus.start = 1'b1; bus.d_in = 8'h00; bus.op = 2'b10; bus.shamt = 3'd1;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        edges = 3;
        while (!bus.done && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check("ign latency", edges, 6);
        check("ign d_out", int'(bus.d_out), 8'h07);
        for (int i = 0; i < 10; i++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        check("ign done_count", dones, 1);

        // Reset mid-shift abandons the operation.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.d_in = 8'hF0; bus.shamt = 3'd6;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);                      // busy cycle 3
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("rst_mid d_out", int'(bus.d_out), 0);
        check("rst_mid busy", int'(bus.busy), 0);
        check("rst_mid done", int'(bus.done), 0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        check("rst_mid no_done", dones, 0);

        // Back-to-back: restart in the done cycle with no idle bubble.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.d_in = 8'h80; bus.shamt = 3'd1;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b busy1", int'(bus.busy), 1);
        @(negedge clk);
        check("b2b done1", int'(bus.done), 1);
        check("b2b d_out1", int'(bus.d_out), 8'h40);
        bus.start = 1'b1; bus.op = 2'b01; bus.d_in = 8'h80; bus.shamt = 3'd2;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b no_bubble", int'(bus.busy), 1);
        edges = 1;
        while (!bus.done && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check("b2b latency2", edges, 3);
        check("b2b d_out2", int'(bus.d_out), 8'hE0);

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom);
            rd = 8'($urandom);
            rs = 3'($urandom_range(0, 7));
            do_op(ro, rd, rs, model(ro, rd, rs), $sformatf("rnd%0d", n));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
